wishbone_arbiter_rr: RTL
========================

# wishbone_arbiter_rr

Round-robin bus arbiter with a bus-timeout watchdog, sitting in front of the shared Wishbone master→slave mux. It decides which of N_MASTER masters owns the shared bus and holds that grant for the whole cycle, including locked cycles. It watches the granted strobe and aborts any access the addressed slave never answers. Its one-hot grant drives the existing master-side mux select.

## Interface
- N_MASTER, 4: number of requesting masters; legal range is 2 or more.
- TIMEOUT, 64: number of consecutive unanswered strobe cycles before an abort; legal range is 2 or more.
- IDX_W, $clog2(N_MASTER): width of the grant index.
- clk_i  in  1  single clock, all logic on its rising edge
- rstn_i  in  1  asynchronous, active-low reset
- cyc_i  in  N_MASTER  per-master cycle request (the master's cyc)
- lock_i  in  N_MASTER  per-master lock; keeps ownership while cyc is low between cycles
- bus_stb_i  in  1  stb of the currently granted master, after the mux
- bus_ack_i  in  1  muxed slave acknowledge
- bus_err_i  in  1  muxed slave error
- bus_rty_i  in  1  muxed slave retry
- gnt_o  out  N_MASTER  one-hot grant, or all zero; registered
- gnt_valid_o  out  1  equals the OR of gnt_o; registered
- gnt_idx_o  out  IDX_W  binary index of the granted master; holds its last value when idle
- to_err_o  out  1  one-cycle timeout error, to be ORed into the granted master's err
- to_count_o  out  8  number of timeout events, saturating at 255

## Operation
- States are IDLE, GRANT and ABORT. A pointer `last` holds the most recently granted index and resets to N_MASTER-1.
- Round-robin pick: the first requester with cyc_i set, searching from last+1 upward and wrapping modulo N_MASTER.
- IDLE:
  - No request: stay in IDLE.
  - Any cyc_i set: go to GRANT with the picked master as g, and set last to g.
- GRANT, ownership check:
  - Ownership holds while cyc_i[g] or lock_i[g] is set.
  - When both are low, release. If another master is requesting, re-pick with the same rule and go directly to GRANT with the new master. Otherwise go to IDLE.
- GRANT, watchdog counter (width $clog2(TIMEOUT)):
  - Define waiting = bus_stb_i AND NOT (ack OR err OR rty).
  - If waiting, the counter increments.
  - If not waiting, the counter clears to 0.
  - If waiting while the counter equals TIMEOUT-1: go to ABORT, clear the counter, and increment to_count_o unless it is already 255.
- ABORT lasts exactly one cycle:
  - to_err_o is 1 and gnt_o is unchanged.
  - Responses arriving in this cycle are ignored by the watchdog.
  - Next state is GRANT with the same master, unless the release condition holds in this cycle; then the release rule above applies.
- Lock requests from masters that are not granted are ignored. A granted master cannot be preempted.
- The watchdog counts only in GRANT. It is held at 0 in IDLE and in ABORT.

## Timing
- Values after reset: gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, to_err_o=0, to_count_o=0, state IDLE, counter 0, last=N_MASTER-1.
- Assertion of rstn_i clears everything immediately at any point, including mid-cycle and during ABORT.
- Grant latency: cyc_i[k] rising in cycle t while IDLE gives gnt_o[k]=1 in cycle t+1.
- Release latency: cyc_i[g] and lock_i[g] both low in cycle t gives the new grant, or all zero, in cycle t+1.
  - gnt_o is never all zero for a cycle when another requester is already waiting.
- Several masters rising in the same cycle: exactly one grant, chosen by the round-robin order.
- Timeout timing: waiting holds from cycle t through t+TIMEOUT-1, which is TIMEOUT cycles; to_err_o is then high only in cycle t+TIMEOUT.
  - A response in cycle t+TIMEOUT-1 prevents the abort.
- Back-to-back timeouts are spaced at least TIMEOUT+1 cycles apart.
- to_err_o is only ever high together with gnt_valid_o=1.

## Test plan
- Reset, then cyc_i=4'b0101 in cycle 0: gnt_o=4'b0001 in cycle 1. Master 0 drops cyc in cycle 3: gnt_o=4'b0100 and gnt_idx_o=2 in cycle 4, with no idle gap.
- Fairness: cyc_i=4'b1111 held, each master drops cyc for one cycle after a 2-cycle transfer. Grant order is 0,1,2,3,0, with the wrap past index 3 back to 0.
- Lock: master 1 is granted, sets lock_i[1]=1 and drops cyc for 3 cycles while master 2 requests. gnt_o stays 4'b0010. Lock falls in cycle t, so gnt_o=4'b0100 in cycle t+1.
- Timeout, TIMEOUT=4: bus_stb_i=1 with no response from cycle 10. to_err_o=1 only in cycle 14 and to_count_o=1. An ack in cycle 13 instead gives no error.
- Saturation: force 256 timeouts. to_count_o ends at 255. The release rule during ABORT leads to IDLE when no master is requesting.
- Asynchronous reset: assert rstn_i=0 mid-ABORT, between clock edges. All outputs go to their reset values before the next edge, and the first grant after release from reset goes to master 0.

Source files
------------

// File: rtl/wishbone_arbiter_rr.sv
// wishbone_arbiter_rr: round-robin owner select for the shared Wishbone bus,
// plus a strobe watchdog that aborts accesses the slave never answers.
module wishbone_arbiter_rr #(
  parameter int N_MASTER = 4,
  parameter int TIMEOUT  = 64,
  parameter int IDX_W    = $clog2(N_MASTER)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [N_MASTER-1:0] cyc_i,
  input  logic [N_MASTER-1:0] lock_i,
  input  logic                bus_stb_i,
  input  logic                bus_ack_i,
  input  logic                bus_err_i,
  input  logic                bus_rty_i,
  output logic [N_MASTER-1:0] gnt_o,
  output logic                gnt_valid_o,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                to_err_o,
  output logic [7:0]          to_count_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   NM       = (IDX_W + 1)'(N_MASTER);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTER - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ABORT} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     last_q;
  logic [CNT_W-1:0]     wd_cnt_q;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W:0]       cand;
  logic [N_MASTER-1:0]  pick_oh;
  logic                 own;
  logic                 waiting;

  // Round-robin search: scan from farthest to nearest so the first requester
  // after last_q (wrapping) is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = N_MASTER; i >= 1; i--) begin
      cand = {1'b0, last_q} + (IDX_W + 1)'(i);
      if (cand >= NM) cand = cand - NM;
      if (cyc_i[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  // One-hot decode of the picked index, one lane per master.
  for (genvar l = 0; l < N_MASTER; l++) begin : g_oh
    assign pick_oh[l] = (pick_idx == IDX_W'(l));
  end

  // last_q always equals the owner while granted, so it doubles as the mux index.
  assign own     = cyc_i[last_q] | lock_i[last_q];
  assign waiting = bus_stb_i & ~(bus_ack_i | bus_err_i | bus_rty_i);

  // Arbitration FSM, watchdog and all registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      last_q      <= LAST_RST;
      wd_cnt_q    <= '0;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      gnt_idx_o   <= '0;
      to_err_o    <= 1'b0;
      to_count_o  <= '0;
    end else begin
      to_err_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            state_q     <= S_GRANT;
            last_q      <= pick_idx;
            gnt_o       <= pick_oh;
            gnt_valid_o <= 1'b1;
            gnt_idx_o   <= pick_idx;
          end
        end
        default: begin
          if (!own) begin
            // Release: hand over directly when someone waits, so no idle gap.
            wd_cnt_q <= '0;
            if (pick_vld) begin
              state_q     <= S_GRANT;
              last_q      <= pick_idx;
              gnt_o       <= pick_oh;
              gnt_valid_o <= 1'b1;
              gnt_idx_o   <= pick_idx;
            end else begin
              state_q     <= S_IDLE;
              gnt_o       <= '0;
              gnt_valid_o <= 1'b0;
            end
          end else if (state_q == S_ABORT) begin
            // Responses during the abort cycle are ignored; counter stays 0.
            state_q <= S_GRANT;
          end else if (waiting) begin
            if (wd_cnt_q == CNT_MAX) begin
              state_q  <= S_ABORT;
              wd_cnt_q <= '0;
              to_err_o <= 1'b1;
              if (to_count_o != 8'hFF) to_count_o <= to_count_o + 8'd1;
            end else begin
              wd_cnt_q <= wd_cnt_q + 1'b1;
            end
          end else begin
            wd_cnt_q <= '0;
          end
        end
      endcase
    end
  end

endmodule
